ssd_display_arbiter: RTL and testbench

//  Shares the single 4-digit seven-segment display (32-bit value feeding SevenSdSignalGen) between NUM_REQ requesters.

---
 rtl/ssd_display_arbiter_pkg.sv | 15 +
 rtl/ssd_display_arbiter_if.sv | 27 ++
 rtl/ssd_display_arbiter_rr_picker.sv | 27 ++
 rtl/ssd_display_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ssd_display_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/ssd_display_arbiter_pkg.sv
// Shared constants and types for the seven-segment display arbiter.
package ssd_pkg;

  localparam int SSD_DIGITS  = 4;
  localparam int SSD_DIGIT_W = 8;
  localparam int SSD_VALUE_W = SSD_DIGITS * SSD_DIGIT_W;
  localparam logic [SSD_VALUE_W-1:0] SSD_BLANK = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_HOLD = 2'd1,
    ARB_GAP  = 2'd2
  } ssd_arb_state_e;

endpackage

// File: rtl/ssd_display_arbiter_if.sv
// Requester/display bundle between the producer blocks and the arbiter.
interface ssd_display_arbiter_if
  import ssd_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*SSD_VALUE_W-1:0] req_data;
  logic [NUM_REQ-1:0]             grant;
  logic [IDX_W-1:0]               owner;
  logic                           busy;
  logic [SSD_VALUE_W-1:0]         value_out;

  modport master (
    output req, req_data,
    input  grant, owner, busy, value_out
  );

  modport slave (
    input  req, req_data,
    output grant, owner, busy, value_out
  );

endinterface

// File: rtl/ssd_display_arbiter_rr_picker.sv
// Round-robin picker: first set request at or above start_i, wrapping at NUM_REQ.
module ssd_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   start_i,
  output logic               found_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan NUM_REQ positions starting at start_i; the first hit wins.
  always_comb begin
    int unsigned k;
    k       = 0;
    found_o = 1'b0;
    idx_o   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(start_i) + i) % NUM_REQ;
      if (!found_o && req_i[IDX_W'(k)]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/ssd_display_arbiter.sv
// Round-robin owner of the shared 4-digit seven-segment display with a
// minimum hold per owner. Optional blank gap between owners: SSD_ARB_GAP_EN.
//
//   state | meaning
//   IDLE  | no owner; arbitrate from rr_ptr, value_out frozen
//   HOLD  | owner granted; value_out tracks its data, hold_cnt counts up
//   GAP   | blank display between owners (SSD_ARB_GAP_EN only)
module ssd_display_arbiter
  import ssd_pkg::*;
#(
  parameter int                     NUM_REQ     = 4,
  parameter int                     HOLD_CYCLES = 100_000_000,
  parameter int                     GAP_CYCLES  = 10_000_000,
  parameter logic [SSD_VALUE_W-1:0] RESET_VALUE = SSD_BLANK
) (
  input logic                  clk,
  input logic                  rst,
  ssd_display_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int HC_W  = $clog2(HOLD_CYCLES + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
  localparam logic [HC_W-1:0] HOLD_MAX  = HC_W'(HOLD_CYCLES);

  localparam logic [1:0] ST_IDLE = ARB_IDLE;
  localparam logic [1:0] ST_HOLD = ARB_HOLD;
`ifdef SSD_ARB_GAP_EN
  localparam logic [1:0] ST_GAP  = ARB_GAP;
  localparam int GC_W = $clog2(GAP_CYCLES + 1);
  localparam logic [GC_W-1:0] GAP_LAST = GC_W'(GAP_CYCLES - 1);
`endif

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("ssd_display_arbiter: NUM_REQ must be 2..8");
  end
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_cycles
    $error("ssd_display_arbiter: HOLD_CYCLES and GAP_CYCLES must be >= 1");
  end

  logic [1:0]             state_q, state_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic                   busy_q, busy_d;
  logic [SSD_VALUE_W-1:0] value_q, value_d;
  logic [HC_W-1:0]        hold_cnt_q, hold_cnt_d;
`ifdef SSD_ARB_GAP_EN
  logic [GC_W-1:0]        gap_cnt_q, gap_cnt_d;
`endif

  logic [SSD_VALUE_W-1:0] data_a [NUM_REQ];
  logic [IDX_W-1:0]       owner_nxt;
  logic [IDX_W-1:0]       pick_start;
  logic                   pick_found;
  logic [IDX_W-1:0]       pick_idx;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_data
    assign data_a[g] = bus.req_data[g*SSD_VALUE_W +: SSD_VALUE_W];
  end

  assign owner_nxt  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
  // While holding, the search must start just past the owner; in IDLE it
  // resumes from wherever the last release left the pointer.
  assign pick_start = (state_q == ST_HOLD) ? owner_nxt : rr_ptr_q;

  ssd_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i   (bus.req),
    .start_i (pick_start),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  // Next-state logic for arbitration, hold timing and the display value.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    busy_d     = busy_q;
    value_d    = value_q;
    hold_cnt_d = hold_cnt_q;
`ifdef SSD_ARB_GAP_EN
    gap_cnt_d  = gap_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d    = ST_HOLD;
          grant_d    = NUM_REQ'(1) << pick_idx;
          owner_d    = pick_idx;
          busy_d     = 1'b1;
          hold_cnt_d = '0;
          value_d    = data_a[pick_idx];
        end
      end
      ST_HOLD: begin
        // Release takes priority over any pending handover; value is frozen.
        if (!bus.req[owner_q]) begin
          grant_d  = '0;
          rr_ptr_d = owner_nxt;
`ifdef SSD_ARB_GAP_EN
          state_d   = ST_GAP;
          busy_d    = 1'b1;
          value_d   = RESET_VALUE;
          gap_cnt_d = GAP_LAST;
`else
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
`endif
        end else if (hold_cnt_q >= HOLD_LAST && pick_found && pick_idx != owner_q) begin
`ifdef SSD_ARB_GAP_EN
          state_d    = ST_GAP;
          grant_d    = '0;
          rr_ptr_d   = owner_nxt;
          value_d    = RESET_VALUE;
          gap_cnt_d  = GAP_LAST;
`else
          grant_d    = NUM_REQ'(1) << pick_idx;
          owner_d    = pick_idx;
          hold_cnt_d = '0;
          value_d    = data_a[pick_idx];
`endif
        end else begin
          value_d = data_a[owner_q];
          if (hold_cnt_q != HOLD_MAX) hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
      end
`ifdef SSD_ARB_GAP_EN
      ST_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q - GC_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      busy_q     <= 1'b0;
      value_q    <= RESET_VALUE;
      hold_cnt_q <= '0;
`ifdef SSD_ARB_GAP_EN
      gap_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      busy_q     <= busy_d;
      value_q    <= value_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef SSD_ARB_GAP_EN
      gap_cnt_q  <= gap_cnt_d;
`endif
    end
  end

  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = busy_q;
  assign bus.value_out = value_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Directed bench for ssd_display_arbiter (NUM_REQ=4, HOLD=8, GAP=3).
// Works with or without SSD_ARB_GAP_EN.
module tb_ssd_display_arbiter;

  localparam int NREQ = 4;
`ifdef SSD_ARB_GAP_EN
  localparam int GAP_N = 3;
`else
  localparam int GAP_N = 0;
`endif

  typedef struct {
    logic [3:0]  g;
    logic        b;
    logic [31:0] v;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;
  exp_t exp_q[$];

  ssd_display_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  ssd_display_arbiter #(
    .NUM_REQ     (NREQ),
    .HOLD_CYCLES (8),
    .GAP_CYCLES  (3),
    .RESET_VALUE (32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [31:0] val);
    bus.req_data[idx*32 +: 32] = val;
  endtask

  // Gap (if any) then one idle cycle before the next grant appears.
  task automatic chk_gap_idle(input string tag, input logic [31:0] idle_val);
    for (int i = 0; i < GAP_N; i++) begin
      chk_eq({tag, "_gap_grant"}, 32'(bus.grant), 32'h0);
      chk_eq({tag, "_gap_busy"}, 32'(bus.busy), 32'h1);
      chk_eq({tag, "_gap_value"}, bus.value_out, 32'hFFFF_FFFF);
      step(1);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.req_data = '0;

    // 1. reset and quiet display
    step(2);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      chk_eq("rst_grant", 32'(bus.grant), 32'h0);
      chk_eq("rst_busy", 32'(bus.busy), 32'h0);
      chk_eq("rst_owner", 32'(bus.owner), 32'h0);
      chk_eq("rst_value", bus.value_out, 32'hFFFF_FFFF);
      step(1);
    end

    // 2. single requester, live data
    set_data(1, 32'h1234_5678);
    bus.req = 4'b0010;
    step(1);
    chk_eq("s2_grant", 32'(bus.grant), 32'h2);
    chk_eq("s2_owner", 32'(bus.owner), 32'h1);
    chk_eq("s2_busy", 32'(bus.busy), 32'h1);
    chk_eq("s2_value", bus.value_out, 32'h1234_5678);
    set_data(1, 32'hAABB_CCDD);
    step(1);
    chk_eq("s2_follow", bus.value_out, 32'hAABB_CCDD);

    // 4. owner 1 drops at hold_cnt=3 while req2 is up
    step(2);
    chk_eq("s4_pre_grant", 32'(bus.grant), 32'h2);
    set_data(1, 32'h1111_1111);
    set_data(2, 32'h2222_2222);
    bus.req = 4'b0100;
    step(1);
    chk_gap_idle("s4", 32'hFFFF_FFFF);
    chk_eq("s4_idle_grant", 32'(bus.grant), 32'h0);
    chk_eq("s4_idle_busy", 32'(bus.busy), 32'h0);
    chk_eq("s4_idle_value", bus.value_out, (GAP_N > 0) ? 32'hFFFF_FFFF : 32'hAABB_CCDD);
    step(1);
    chk_eq("s4_grant2", 32'(bus.grant), 32'h4);
    chk_eq("s4_value2", bus.value_out, 32'h2222_2222);

    // 5. owner alone past expiry, then req3 rises
    step(20);
    chk_eq("s5_alone_grant", 32'(bus.grant), 32'h4);
    set_data(3, 32'h3333_3333);
    bus.req = 4'b1100;
    step(1);
    if (GAP_N > 0) begin
      chk_gap_idle("s5", 32'hFFFF_FFFF);
      chk_eq("s5_idle_busy", 32'(bus.busy), 32'h0);
      step(1);
    end
    chk_eq("s5_grant3", 32'(bus.grant), 32'h8);
    chk_eq("s5_owner3", 32'(bus.owner), 32'h3);
    chk_eq("s5_value3", bus.value_out, 32'h3333_3333);

    // 6. reset mid-hold
    step(2);
    rst = 1'b1;
    step(1);
    chk_eq("s6_grant", 32'(bus.grant), 32'h0);
    chk_eq("s6_busy", 32'(bus.busy), 32'h0);
    chk_eq("s6_owner", 32'(bus.owner), 32'h0);
    chk_eq("s6_value", bus.value_out, 32'hFFFF_FFFF);

    // 3. continuous req=1011: owners 0,1,3,0, 8 cycles each
    set_data(0, 32'hD0D0_D0D0);
    bus.req = 4'b1011;
    rst = 1'b0;
    step(1);
    begin
      int own [3] = '{0, 1, 3};
      logic [31:0] dat [4] = '{32'hD0D0_D0D0, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      for (int o = 0; o < 3; o++) begin
        for (int c = 0; c < 8; c++)
          exp_q.push_back('{g: 4'(1 << own[o]), b: 1'b1, v: dat[own[o]]});
        for (int c = 0; c < GAP_N; c++)
          exp_q.push_back('{g: 4'h0, b: 1'b1, v: 32'hFFFF_FFFF});
        if (GAP_N > 0)
          exp_q.push_back('{g: 4'h0, b: 1'b0, v: 32'hFFFF_FFFF});
      end
      exp_q.push_back('{g: 4'h1, b: 1'b1, v: dat[0]});
    end
    foreach (exp_q[k]) begin
      chk_eq($sformatf("s3_grant_%0d", k), 32'(bus.grant), 32'(exp_q[k].g));
      chk_eq($sformatf("s3_busy_%0d", k), 32'(bus.busy), 32'(exp_q[k].b));
      chk_eq($sformatf("s3_value_%0d", k), bus.value_out, exp_q[k].v);
      step(1);
    end

    // reset mid-gap
    if (GAP_N > 0) begin
      step(8);
      chk_eq("s6g_in_gap_busy", 32'(bus.busy), 32'h1);
      chk_eq("s6g_in_gap_grant", 32'(bus.grant), 32'h0);
      rst = 1'b1;
      step(1);
      chk_eq("s6g_busy", 32'(bus.busy), 32'h0);
      chk_eq("s6g_owner", 32'(bus.owner), 32'h0);
      chk_eq("s6g_value", bus.value_out, 32'hFFFF_FFFF);
      rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
